char_buffer_arbiter: RTL and testbench

Single-port arbiter and sequencer for the character buffer (80x24 = 1920 bytes, 11-bit address).
- Video fetch owns the port during active display.
- Host character writes (terminal/UART side) and a hardware clear-screen sequencer share the port during blanking.
- Sits between sync_generator/fetch logic and char_buffer; drives the buffer's address, data and write-enable.

---
 rtl/char_buffer_arbiter.sv | 115 +++++++++++
 tb/tb_char_buffer_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/char_buffer_arbiter.sv
// Character-buffer port arbiter: video fetch, host writes and a clear-screen sequencer.
// Define SCROLL_OFFSET_EN to add the base_row input that rotates the video address by whole rows.
module char_buffer_arbiter #(
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 24,
    parameter int unsigned AW        = 11,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic          px_clk,
    input  logic          clr_n,
    input  logic          vid_active,
    input  logic [AW-1:0] vid_addr,
`ifdef SCROLL_OFFSET_EN
    input  logic [4:0]    base_row,
`endif
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_ack,
    input  logic          cls_req,
    output logic          cls_busy,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_wen
);

    localparam int unsigned  DEPTH    = COLS * ROWS;
    localparam logic [AW:0]  DEPTH_X  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          cls_busy_q, cls_busy_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_din_q, mem_din_d;
    logic          mem_wen_q, mem_wen_d;
    logic          wr_ack_q, wr_ack_d;
    logic [AW-1:0] vid_phys;

`ifdef SCROLL_OFFSET_EN
    logic [AW:0] row_off;
    logic [AW:0] vid_sum;

    // vid_addr < DEPTH and row_off < DEPTH, so one conditional subtract wraps the sum.
    always_comb begin
        row_off  = (32'(base_row) < ROWS) ? (AW + 1)'(32'(base_row) * COLS) : '0;
        vid_sum  = {1'b0, vid_addr} + row_off;
        vid_phys = (vid_sum >= DEPTH_X) ? AW'(vid_sum - DEPTH_X) : vid_sum[AW-1:0];
    end
`else
    assign vid_phys = vid_addr;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cls_busy_d = cls_busy_q | cls_req;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_wen_d  = 1'b0;
        wr_ack_d   = 1'b0;

        if (vid_active) begin
            mem_addr_d = vid_phys;
        end else if (state_q == StClear || cls_busy_q) begin
            mem_addr_d = ptr_q;
            mem_din_d  = FILL_CHAR;
            mem_wen_d  = 1'b1;
            if (ptr_q == LAST_PTR) begin
                ptr_d      = '0;
                state_d    = StIdle;
                cls_busy_d = 1'b0;
            end else begin
                ptr_d   = ptr_q + 1'b1;
                state_d = StClear;
            end
        end else if (wr_req && !wr_ack_q && !cls_req) begin
            // A clear request arriving this cycle takes the port first.
            mem_addr_d = wr_addr;
            mem_din_d  = wr_data;
            mem_wen_d  = ({1'b0, wr_addr} < DEPTH_X);
            wr_ack_d   = 1'b1;
        end
    end

    always_ff @(posedge px_clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cls_busy_q <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_wen_q  <= 1'b0;
            wr_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cls_busy_q <= cls_busy_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_wen_q  <= mem_wen_d;
            wr_ack_q   <= wr_ack_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_wen  = mem_wen_q;
    assign wr_ack   = wr_ack_q;
    assign cls_busy = cls_busy_q;

endmodule

// File: tb/tb_char_buffer_arbiter.sv
// Scoreboard bench for char_buffer_arbiter: expected buffer writes are queued at stimulus time
// and retired in order as mem_wen pulses appear.
module tb_char_buffer_arbiter;

    localparam int unsigned DEPTH = 1920;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        px_clk     = 1'b0;
    logic        clr_n      = 1'b0;
    logic        vid_active = 1'b1;
    logic [10:0] vid_addr   = '0;
    logic        wr_req     = 1'b0;
    logic [10:0] wr_addr    = '0;
    logic [7:0]  wr_data    = '0;
    logic        cls_req    = 1'b0;
    logic        wr_ack;
    logic        cls_busy;
    logic [10:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_wen;
`ifdef SCROLL_OFFSET_EN
    logic [4:0]  base_row   = '0;
`endif

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t exp_q[$];
    wr_t mon_e;
    logic vid_q = 1'b1;

    char_buffer_arbiter dut (
        .px_clk    (px_clk),
        .clr_n     (clr_n),
        .vid_active(vid_active),
        .vid_addr  (vid_addr),
`ifdef SCROLL_OFFSET_EN
        .base_row  (base_row),
`endif
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .cls_req   (cls_req),
        .cls_busy  (cls_busy),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_wen   (mem_wen)
    );

    always #5 px_clk = ~px_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; drives and direct checks happen here.
    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask

    task automatic push_wr(input logic [10:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_clear();
        for (int i = 0; i < int'(DEPTH); i++) push_wr(11'(i), 8'h20);
    endtask

    task automatic host_write(input logic [10:0] a, input logic [7:0] d, input int budget,
                              output int lat);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        if (a < 11'(DEPTH)) push_wr(a, d);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!wr_ack && lat < budget);
        check("ack_seen", wr_ack, 1);
        check("ack_wen", mem_wen, (a < 11'(DEPTH)));
        check("ack_addr", mem_addr, a);
        check("ack_din", mem_din, d);
        wr_req = 1'b0;
        tick();
        check("ack_pulse", wr_ack, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_din"}, mem_din, 0);
        check({tag, "_wen"}, mem_wen, 0);
        check({tag, "_ack"}, wr_ack, 0);
        check({tag, "_busy"}, cls_busy, 0);
    endtask

    always @(posedge px_clk) vid_q <= vid_active;

    always @(negedge px_clk) begin
        if (clr_n && mem_wen) begin
            check("wen_in_video", vid_q, 0);
            if (exp_q.size() == 0) begin
                check("extra_write", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", mem_addr, mon_e.addr);
                check("wr_data", mem_din, mon_e.data);
            end
        end
    end

    initial begin
        int lat;
        int n;

        // Reset state and registered video path.
        #2;
        check_all_zero("rst");
        @(posedge px_clk);
        #1;
        clr_n    = 1'b1;
        vid_addr = 11'd5;
        tick();
        check("vid_addr", mem_addr, 5);
        check("vid_wen", mem_wen, 0);

        // Host writes during blanking, including the out-of-range drop.
        vid_active = 1'b0;
        host_write(11'd100, 8'h41, 10, lat);
        check("wr_latency", lat, 1);
        host_write(11'd1920, 8'h42, 10, lat);
        host_write(11'd1919, 8'h7e, 10, lat);
        tick();
        check("idle_wen", mem_wen, 0);
        check("idle_hold", mem_addr, 1919);

        // Host request stalled behind video.
        vid_active = 1'b1;
        vid_addr   = 11'd7;
        wr_req     = 1'b1;
        wr_addr    = 11'd200;
        wr_data    = 8'h33;
        push_wr(11'd200, 8'h33);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("stall_ack", wr_ack, 0);
            check("stall_wen", mem_wen, 0);
        end
        vid_active = 1'b0;
        tick();
        check("stall_release", wr_ack, 1);
        check("stall_addr", mem_addr, 200);
        wr_req = 1'b0;
        tick();

        // Reset in the middle of a clear aborts it immediately.
        cls_req = 1'b1;
        push_clear();
        tick();
        cls_req = 1'b0;
        repeat (30) tick();
        #2;
        clr_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        exp_q.delete();
        @(posedge px_clk);
        #1;
        clr_n = 1'b1;
        tick();
        check("post_rst_busy", cls_busy, 0);
        check("post_rst_wen", mem_wen, 0);

        // Full clear from pointer 0 with a redundant request mid-way.
        cls_req = 1'b1;
        push_clear();
        tick();
        cls_req = 1'b0;
        check("cls_busy_set", cls_busy, 1);
        n = 0;
        while (cls_busy && n < 3000) begin
            cls_req = (n == 500);
            tick();
            n++;
        end
        cls_req = 1'b0;
        check("clear_done", cls_busy, 0);
        repeat (10) tick();
        check("clear_left", exp_q.size(), 0);
        check("clear_idle_wen", mem_wen, 0);

        // Clear interrupted by video, with a host write requested in the same cycle.
        cls_req = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 11'd300;
        wr_data = 8'h55;
        push_clear();
        push_wr(11'd300, 8'h55);
        tick();
        cls_req = 1'b0;
        check("same_cycle_ack", wr_ack, 0);
        n = 0;
        while (!wr_ack && n < 8000) begin
            if (n > 0 && n % 100 == 0) vid_active = ~vid_active;
            vid_addr = 11'(n % 1920);
            tick();
            n++;
            if (wr_ack) check("ack_busy", cls_busy, 0);
        end
        check("intr_ack", wr_ack, 1);
        wr_req     = 1'b0;
        vid_active = 1'b0;
        repeat (5) tick();
        check("intr_left", exp_q.size(), 0);

        // Video address translation.
        vid_active = 1'b1;
        vid_addr   = 11'd1800;
`ifdef SCROLL_OFFSET_EN
        base_row = 5'd2;
        tick();
        check("scroll_wrap", mem_addr, 40);
        base_row = 5'd30;
        tick();
        check("scroll_oob", mem_addr, 1800);
        base_row = 5'd23;
        vid_addr = 11'd0;
        tick();
        check("scroll_top", mem_addr, 1840);
        vid_addr = 11'd100;
        tick();
        check("scroll_wrap2", mem_addr, 20);
`else
        tick();
        check("vid_pass", mem_addr, 1800);
`endif
        check("vid_no_wen", mem_wen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
